vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing generator: it samples an incoming vga_hs / vga_vs / vga_rgb stream and recovers pixel and line position from the sync edges.
- It verifies line timing, then writes a fixed rectangular window of each frame into a frame-buffer RAM through a simple write port.
- It sits between an external VGA source (or the in-house generator in loopback) and a dual-port RAM of WIN_W*WIN_H bytes.

Parameters:
H_TOTAL  1056  expected clocks per line (hs falling edge to hs falling edge)
V_TOTAL  628   expected lines per frame
WIN_X0   516   first captured column (hcnt value)
WIN_W    200   captured columns per line
WIN_Y0   252   first captured line (vcnt value)
WIN_H    150   captured lines per frame
LOCK_N   4     consecutive good lines required for lock
ADDR_W   15    write address width; must satisfy 2^ADDR_W >= WIN_W*WIN_H

Ports:
vga_clk     in   1       pixel clock; all logic on rising edge
rst         in   1       asynchronous, active-high reset
vga_hs      in   1       horizontal sync, active low
vga_vs      in   1       vertical sync, active low
vga_rgb     in   8       pixel data
wr_en       out  1       frame-buffer write strobe
wr_addr     out  ADDR_W  frame-buffer write address
wr_data     out  8       frame-buffer write data
frame_done  out  1       1-cycle pulse after the last window pixel is written
frame_err   out  1       1-cycle pulse when a capture is aborted
lock        out  1       high while line timing matches H_TOTAL

Behaviour:
- Reset (rst=1, asynchronous): all outputs 0; all counters 0; state IDLE; input registers set to hs=1, vs=1, rgb=0.
- Input stage: hs, vs and rgb each pass through one register stage. Edge detection uses the registered value and its one-cycle-delayed copy. A falling edge = previous 1, current 0.
- hcnt (11 bit):
  - 0 on a hs falling edge, else +1.
  - Saturates at 2047 with no wrap.
- vcnt (10 bit):
  - 0 on a vs falling edge.
  - Otherwise +1 on a hs falling edge, else hold.
  - Saturates at 1023.
  - A vs falling edge in the same cycle as a hs falling edge gives vcnt=0 (vs has priority).
- Line check:
  - On every hs falling edge, the line is good if hcnt(before clear)==H_TOTAL-1.
  - good_cnt increments on a good line, saturating at LOCK_N.
  - A bad line, or hcnt reaching 2047, clears good_cnt.
  - The first hs edge after reset is never counted as good.
- lock = (good_cnt==LOCK_N), registered.
- FSM:
  - IDLE: wait until lock=1, then go to ARMED.
  - ARMED: on a vs falling edge, set wr_addr to 0 and go to CAPTURE. If lock drops, go to IDLE with no frame_err.
  - CAPTURE: write the window.
    - A pixel is in the window when WIN_X0 <= hcnt < WIN_X0+WIN_W and WIN_Y0 <= vcnt < WIN_Y0+WIN_H.
    - For each window pixel: wr_en=1 and wr_data=registered rgb in the same cycle. wr_addr carries the current address, and the address increments after each write.
    - When the write at address WIN_W*WIN_H-1 completes, pulse frame_done the next cycle and go to ARMED.
  - Abort from CAPTURE: if lock drops, or a vs falling edge arrives before the last pixel, pulse frame_err and set wr_en=0.
    - Lock dropped: go to IDLE.
    - Early vs: restart immediately as a new frame with wr_addr=0, staying in CAPTURE.
- Latency: a pixel presented on vga_rgb at source column c appears on wr_data 2 clocks later, at receiver hcnt==c, aligned with hs.
- wr_en is 0 in every state except CAPTURE. wr_addr never exceeds WIN_W*WIN_H-1.
- Reset asserted mid-frame: outputs clear immediately. No frame_done or frame_err is issued for the interrupted frame.

Test Plan:
- Nominal 1056x628 stimulus (hs low 128 clocks, vs low 4 lines) with rgb = column[7:0]:
  - lock rises after the 5th hs falling edge.
  - The first full frame produces exactly 30000 wr_en pulses, addresses 0..29999.
  - wr_data at address 0 = 516&255 = 4; at address 199 = 203.
  - Exactly one frame_done follows the write to address 29999.
- Lock timing: lock rises only after 4 consecutive good lines. Inject one 1055-clock line mid-capture:
  - frame_err pulses once and lock falls.
  - After 4 good lines, capture resumes at the next vs with wr_addr=0.
- Early vs: shorten a frame to 400 lines.
  - frame_err pulses once, no frame_done.
  - The next window write uses address 0.
- Simultaneous hs and vs falling edges: vcnt=0, and the first window write occurs on line 252, hcnt 516.
- Async reset asserted at wr_addr=12345:
  - All outputs read 0 before the next clock edge.
  - After release, no writes occur until lock is reacquired and a vs edge arrives.
- Sync loss: hs held high for 3000 clocks drops lock and clears good_cnt. No wr_en while hcnt is saturated.

Source files
------------

// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
//  Module      : vga_capture
//  Description : Samples an incoming VGA hs/vs/rgb stream and recovers pixel
//                and line position from the sync edges. It checks line length,
//                declares lock after a run of good lines, and writes a fixed
//                rectangular window of each locked frame into a frame-buffer
//                RAM through a simple write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_capture #(
    parameter int H_TOTAL = 1056,  // expected clocks per line
    parameter int V_TOTAL = 628,   // expected lines per frame
    parameter int WIN_X0  = 516,   // first captured column
    parameter int WIN_W   = 200,   // captured columns per line
    parameter int WIN_Y0  = 252,   // first captured line
    parameter int WIN_H   = 150,   // captured lines per frame
    parameter int LOCK_N  = 4,     // consecutive good lines for lock
    parameter int ADDR_W  = 15     // frame-buffer address width
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              vga_hs,
    input  logic              vga_vs,
    input  logic [7:0]        vga_rgb,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              lock
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [10:0] c_HCNT_MAX = 11'd2047;
    localparam logic [9:0]  c_VCNT_MAX = 10'd1023;
    localparam logic [10:0] c_H_LAST   = 11'(H_TOTAL - 1);

    localparam logic [10:0] c_X_BEG    = 11'(WIN_X0);
    localparam logic [10:0] c_X_END    = 11'(WIN_X0 + WIN_W);
    // Rows beyond the frame height can never arrive, so the window is
    // clipped to the frame.
    localparam int          c_Y_END_I  = ((WIN_Y0 + WIN_H) < V_TOTAL) ?
                                         (WIN_Y0 + WIN_H) : V_TOTAL;
    localparam logic [9:0]  c_Y_BEG    = 10'(WIN_Y0);
    localparam logic [9:0]  c_Y_END    = 10'(c_Y_END_I);

    localparam int                  c_GOOD_W    = $clog2(LOCK_N + 1);
    localparam logic [c_GOOD_W-1:0] c_LOCK_N    = c_GOOD_W'(LOCK_N);
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR = ADDR_W'(WIN_W * WIN_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                r_hs;
    logic                r_hs_d;
    logic                r_vs;
    logic                r_vs_d;
    logic [7:0]          r_rgb;
    logic [7:0]          r_rgb_d;

    logic                w_hs_fall;
    logic                w_vs_fall;

    logic [10:0]         r_hcnt;
    logic [9:0]          r_vcnt;

    logic                r_seen_hs;
    logic [c_GOOD_W-1:0] r_good_cnt;
    logic                r_lock;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   w_wr_addr_nxt;
    logic                w_wr_en;
    logic                w_in_win;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                r_frame_done;
    logic                r_frame_err;

    // ------------------------------------------------------------------
    // Input register stage plus one delayed copy for edge detection.
    // The delayed rgb copy lines pixel data up with the recovered hcnt.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_hs    <= 1'b1;
            r_hs_d  <= 1'b1;
            r_vs    <= 1'b1;
            r_vs_d  <= 1'b1;
            r_rgb   <= 8'd0;
            r_rgb_d <= 8'd0;
        end else begin
            r_hs    <= vga_hs;
            r_hs_d  <= r_hs;
            r_vs    <= vga_vs;
            r_vs_d  <= r_vs;
            r_rgb   <= vga_rgb;
            r_rgb_d <= r_rgb;
        end
    end

    assign w_hs_fall = r_hs_d & ~r_hs;
    assign w_vs_fall = r_vs_d & ~r_vs;

    // ------------------------------------------------------------------
    // Pixel counter: cleared by hs falling edge, saturates without wrap
    // so a missing sync is visible as a pinned count.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_hcnt <= 11'd0;
        end else if (w_hs_fall) begin
            r_hcnt <= 11'd0;
        end else if (r_hcnt != c_HCNT_MAX) begin
            r_hcnt <= r_hcnt + 11'd1;
        end
    end

    // ------------------------------------------------------------------
    // Line counter: vs falling edge wins over a coincident hs edge.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_vcnt <= 10'd0;
        end else if (w_vs_fall) begin
            r_vcnt <= 10'd0;
        end else if (w_hs_fall && (r_vcnt != c_VCNT_MAX)) begin
            r_vcnt <= r_vcnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Line-length check. The first hs edge after reset closes a line of
    // unknown length, so it is never counted as good.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_seen_hs  <= 1'b0;
            r_good_cnt <= '0;
        end else if (w_hs_fall) begin
            r_seen_hs <= 1'b1;
            if (r_seen_hs && (r_hcnt == c_H_LAST)) begin
                if (r_good_cnt != c_LOCK_N) begin
                    r_good_cnt <= r_good_cnt + 1'b1;
                end
            end else begin
                r_good_cnt <= '0;
            end
        end else if (r_hcnt == c_HCNT_MAX) begin
            r_good_cnt <= '0;
        end
    end

    // Registered lock flag derived from the good-line run length
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else begin
            r_lock <= (r_good_cnt == c_LOCK_N);
        end
    end

    // ------------------------------------------------------------------
    // Capture window decode on the recovered position
    // ------------------------------------------------------------------
    assign w_in_win = (r_hcnt >= c_X_BEG) && (r_hcnt < c_X_END) &&
                      (r_vcnt >= c_Y_BEG) && (r_vcnt < c_Y_END);

    // Capture FSM state register
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture FSM next-state, write strobe and address/pulse next values
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_en       = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_lock) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!r_lock) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_vs_fall) begin
                    w_state_nxt   = ST_CAPTURE;
                    w_wr_addr_nxt = '0;
                end
            end
            ST_CAPTURE: begin
                if (!r_lock) begin
                    // Timing lost mid-frame: abandon and wait for relock
                    w_err_nxt     = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_wr_addr_nxt = '0;
                end else if (w_vs_fall) begin
                    // Frame ended early: report it and treat the new vs
                    // as the start of a fresh frame
                    w_err_nxt     = 1'b1;
                    w_wr_addr_nxt = '0;
                end else if (w_in_win) begin
                    w_wr_en = 1'b1;
                    if (r_wr_addr == c_LAST_ADDR) begin
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = ST_ARMED;
                        w_wr_addr_nxt = '0;
                    end else begin
                        w_wr_addr_nxt = r_wr_addr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_wr_addr_nxt = '0;
            end
        endcase
    end

    // Write address and one-cycle status pulses
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_wr_addr    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_wr_addr    <= w_wr_addr_nxt;
            r_frame_done <= w_done_nxt;
            r_frame_err  <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_en      = w_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = w_wr_en ? r_rgb_d : 8'd0;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign lock       = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_capture
//  Description : Self-checking bench for vga_capture using a reduced raster
//                (64 x 40, 8 x 5 window at column 20 / line 10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

    localparam int H_TOTAL  = 64;
    localparam int V_TOTAL  = 40;
    localparam int WIN_X0   = 20;
    localparam int WIN_W    = 8;
    localparam int WIN_Y0   = 10;
    localparam int WIN_H    = 5;
    localparam int LOCK_N   = 4;
    localparam int ADDR_W   = 6;
    localparam int HS_LEN   = 8;
    localparam int VS_LINES = 2;
    localparam int LAST     = WIN_W * WIN_H - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              vga_hs;
    logic              vga_vs;
    logic [7:0]        vga_rgb;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              frame_err;
    logic              lock;

    always #5 clk = ~clk;

    vga_capture #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .WIN_X0  (WIN_X0),
        .WIN_W   (WIN_W),
        .WIN_Y0  (WIN_Y0),
        .WIN_H   (WIN_H),
        .LOCK_N  (LOCK_N),
        .ADDR_W  (ADDR_W)
    ) dut (
        .vga_clk    (clk),
        .rst        (rst),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_rgb    (vga_rgb),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .lock       (lock)
    );

    typedef struct {
        int vlen;        // lines in this frame
        int short_line;  // line that is one clock short, -1 for none
        int exp_wr;
        int exp_done;
        int exp_err;     // err pulses seen while this frame's lines play
        int exp_lock;    // lock at end of frame
    } frame_vec_t;

    frame_vec_t vecs [5];

    int n_assert = 0;
    int n_fail   = 0;

    // Source raster position and shape
    int src_col    = 0;
    int src_line   = 0;
    int cur_vlen   = V_TOTAL;
    int short_line = -1;
    bit hold       = 1'b0;

    // Observed totals
    int tot_wr   = 0;
    int tot_done = 0;
    int tot_err  = 0;
    bit prev_last = 1'b0;
    int d0 = -1, d7 = -1, w0_line = -1, w0_col = -1;
    int s_wr, s_done, s_err;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one source column, observe the DUT after the edge, advance.
    task automatic tick();
        int  pcol;
        int  exp_addr;
        bit  in_win;
        if (hold) begin
            vga_hs  = 1'b1;
            vga_vs  = 1'b1;
            vga_rgb = 8'd0;
        end else begin
            vga_hs  = (src_col < HS_LEN) ? 1'b0 : 1'b1;
            vga_vs  = (src_line < VS_LINES) ? 1'b0 : 1'b1;
            vga_rgb = 8'(src_col);
        end
        @(posedge clk);
        #1;
        if (frame_done) begin
            tot_done++;
            chk("frame_done_follows_last_write", int'(prev_last), 1);
        end
        if (frame_err) tot_err++;
        prev_last = wr_en && (int'(wr_addr) == LAST);
        if (wr_en) begin
            tot_wr++;
            // receiver hcnt trails the column just sampled by one
            pcol     = src_col - 1;
            in_win   = !hold && (pcol >= WIN_X0) && (pcol < WIN_X0 + WIN_W) &&
                       (src_line >= WIN_Y0) && (src_line < WIN_Y0 + WIN_H);
            exp_addr = (src_line - WIN_Y0) * WIN_W + (pcol - WIN_X0);
            chk("wr_in_window", int'(in_win), 1);
            chk("wr_addr", int'(wr_addr), exp_addr);
            chk("wr_data", int'(wr_data), pcol & 255);
            if (wr_addr == '0) begin
                d0      = int'(wr_data);
                w0_line = src_line;
                w0_col  = pcol;
            end
            if (int'(wr_addr) == WIN_W - 1) d7 = int'(wr_data);
        end
        @(negedge clk);
        if (!hold) begin
            src_col++;
            if (src_col == ((src_line == short_line) ? H_TOTAL - 1 : H_TOTAL)) begin
                src_col = 0;
                src_line++;
                if (src_line == cur_vlen) src_line = 0;
            end
        end
    endtask

    task automatic run_frame();
        do tick(); while ((src_line != 0) || (src_col != 0));
    endtask

    task automatic snap();
        s_wr   = tot_wr;
        s_done = tot_done;
        s_err  = tot_err;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_lock"}, int'(lock), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            vlen    short  wr  done err lock
        vecs[0] = '{V_TOTAL, -1,    40, 1,   0,  1};  // nominal capture
        vecs[1] = '{V_TOTAL, 12,    24, 0,   1,  1};  // short line mid-window
        vecs[2] = '{V_TOTAL, -1,    40, 1,   0,  1};  // resumes at address 0
        vecs[3] = '{12,      -1,    16, 0,   0,  1};  // frame cut short
        vecs[4] = '{V_TOTAL, -1,    40, 1,   1,  1};  // early vs reported, restart

        rst     = 1'b1;
        vga_hs  = 1'b1;
        vga_vs  = 1'b1;
        vga_rgb = 8'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Startup frame: lock rises two clocks after the 5th hs edge
        while (!((src_line == 4) && (src_col == 2))) tick();
        chk("lock_before_5th_edge_settles", int'(lock), 0);
        tick();
        chk("lock_after_5th_edge", int'(lock), 1);
        snap();
        while ((src_line != 0) || (src_col != 0)) tick();
        chk("startup_frame_writes", tot_wr - s_wr, 0);

        for (int i = 0; i < 5; i++) begin
            cur_vlen   = vecs[i].vlen;
            short_line = vecs[i].short_line;
            snap();
            run_frame();
            chk($sformatf("frame%0d_writes", i), tot_wr - s_wr, vecs[i].exp_wr);
            chk($sformatf("frame%0d_done", i), tot_done - s_done, vecs[i].exp_done);
            chk($sformatf("frame%0d_err", i), tot_err - s_err, vecs[i].exp_err);
            chk($sformatf("frame%0d_lock", i), int'(lock), vecs[i].exp_lock);
        end
        cur_vlen   = V_TOTAL;
        short_line = -1;

        chk("data_at_addr0", d0, WIN_X0 & 255);
        chk("data_at_addr_w_minus_1", d7, (WIN_X0 + WIN_W - 1) & 255);
        chk("first_write_line", w0_line, WIN_Y0);
        chk("first_write_col", w0_col, WIN_X0);

        // Asynchronous reset in the middle of a capture (address 20)
        while (!((src_line == 12) && (src_col == 26))) tick();
        chk("pre_reset_wr_en", int'(wr_en), 1);
        chk("pre_reset_wr_addr", int'(wr_addr), 20);
        snap();
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        repeat (3) tick();
        rst = 1'b0;
        while ((src_line != 0) || (src_col != 0)) tick();
        chk("after_reset_writes", tot_wr - s_wr, 0);
        chk("after_reset_done", tot_done - s_done, 0);
        chk("after_reset_err", tot_err - s_err, 0);
        snap();
        run_frame();
        chk("relock_frame_writes", tot_wr - s_wr, 40);
        chk("relock_frame_done", tot_done - s_done, 1);
        chk("relock_frame_err", tot_err - s_err, 0);

        // Sync loss: hs stuck high long enough for hcnt to saturate
        snap();
        hold = 1'b1;
        repeat (3000) tick();
        hold = 1'b0;
        chk("sync_loss_lock", int'(lock), 0);
        chk("sync_loss_writes", tot_wr - s_wr, 0);
        chk("sync_loss_err", tot_err - s_err, 0);
        while (!((src_line == 3) && (src_col == 10))) tick();
        chk("resync_lock_line3", int'(lock), 0);
        while (!((src_line == 4) && (src_col == 10))) tick();
        chk("resync_lock_line4", int'(lock), 1);
        while ((src_line != 0) || (src_col != 0)) tick();
        chk("resync_frame_writes", tot_wr - s_wr, 0);
        snap();
        run_frame();
        chk("post_resync_writes", tot_wr - s_wr, 40);
        chk("post_resync_done", tot_done - s_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
